// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing from the pixel clock.
//
// Ports:
//   vga_clk      pixel clock, all logic on posedge
//   reset_n      asynchronous active-low reset
//   pixel_ce     counter advance enable (tie high for 25 MHz operation)
//   DrawX/DrawY  current raster position (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   blank        1 = active video
//   hs/vs        horizontal/vertical sync, active low
//   line_end     strobe on the last pixel of each line
//   frame_start  strobe when the raster wraps back to (0,0)
//   frame_count  completed frames, wraps 255->0
//
// Flags are decoded from the next-state counters and registered together with
// the counters, so every output describes the same pixel as DrawX/DrawY.
// The two strobes are additionally qualified by pixel_ce so a frozen raster
// never shows a strobe on a non-advancing cycle.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pixel_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_end,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned CW      = 10;
  localparam int unsigned FW      = 8;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Counters are 10 bits wide; larger totals cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          blank_q, blank_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          le_q, le_d;
  logic          fs_q, fs_d;
  logic          wrap_x, wrap_y;

  assign wrap_x = (x_q == H_LAST);
  assign wrap_y = (y_q == V_LAST);

  // Next raster position and the flags that describe it; hold when not advancing.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;
    blank_d = blank_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    le_d    = le_q;
    fs_d    = fs_q;
    if (pixel_ce) begin
      x_d = wrap_x ? '0 : x_q + CW'(1);
      if (wrap_x) begin
        y_d = wrap_y ? '0 : y_q + CW'(1);
      end
      if (wrap_x && wrap_y) begin
        fc_d = fc_q + FW'(1);
      end
      blank_d = (x_d < H_VIS) && (y_d < V_VIS);
      hs_d    = !((x_d >= HS_BEG) && (x_d < HS_END));
      vs_d    = !((y_d >= VS_BEG) && (y_d < VS_END));
      le_d    = (x_d == H_LAST);
      fs_d    = wrap_x && wrap_y;
    end
  end

  // Raster state and registered flags.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      blank_q <= 1'b1;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      le_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      le_q    <= le_d;
      fs_q    <= fs_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_count = fc_q;
  // A frozen strobe register must not be seen again while the raster is held.
  assign line_end    = le_q & pixel_ce;
  assign frame_start = fs_q & pixel_ce;

endmodule
